// File: rtl/srp_circ_capture_buff.sv
// Circular capture buffer for the Shapiro-Rudin-Park time synchronizer.
// Samples stream into a DEPTH-entry RAM; after the buffer has filled once, a
// trigger starts a post-trigger count, and after POST_TRIG more stored samples
// the buffer freezes so the back end can read the window relative to the
// newest sample.
//
// Handshake: there is no backpressure. A write happens on every cycle where
// in_valid=1 and the buffer is not frozen. A read request (rd_en=1) is always
// accepted and answered exactly one cycle later with rd_valid=1. rd_data and
// rd_oob are meaningful only while rd_valid=1; rd_data holds between reads.
module srp_circ_capture_buff #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 2240,
  parameter int ADDR_W    = 12,
  parameter int POST_TRIG = 1120
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     trig,
  input  logic                     rearm,
  input  logic                     rd_en,
  input  logic        [ADDR_W-1:0] rd_offset,
  output logic                     rd_valid,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     rd_oob,
  output logic                     full,
  output logic                     frozen
);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   FILL_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_TRIG - 1);

  state_t                    state;
  logic [ADDR_W-1:0]         wr_ptr;
  logic [ADDR_W:0]           fill_cnt;
  logic [ADDR_W-1:0]         post_cnt;
  logic signed [DATA_W-1:0]  mem [DEPTH];

  logic                      wr_en;
  logic [ADDR_W:0]           rd_diff;
  logic [ADDR_W-1:0]         rd_addr;
  logic                      rd_in_range;

  // Write qualification and read address: newest sample sits at wr_ptr-1.
  // The subtraction is one bit wider so a negative result shows in the MSB
  // and is folded back into range by adding DEPTH once.
  always_comb begin
    wr_en       = in_valid && (state != ST_FROZEN);
    rd_diff     = {1'b0, wr_ptr} - {1'b0, rd_offset} - (ADDR_W+1)'(1);
    rd_addr     = rd_diff[ADDR_W] ? ADDR_W'(rd_diff + DEPTH_X) : rd_diff[ADDR_W-1:0];
    rd_in_range = ({1'b0, rd_offset} < DEPTH_X);
  end

  // Sample RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  // Registered read port, read-first with respect to a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_oob   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_oob   <= rd_en && !rd_in_range;
      if (rd_en) rd_data <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

  // Write pointer: wraps DEPTH-1 -> 0, held while frozen (wr_en low).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
    end
  end

  // Capture FSM with fill/post counters and registered full/frozen flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FILL;
      fill_cnt <= '0;
      post_cnt <= '0;
      full     <= 1'b0;
      frozen   <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          // fill_cnt only counts here, so it saturates at DEPTH naturally.
          if (wr_en) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == FILL_LAST) begin
              state <= ST_ARMED;
              full  <= 1'b1;
            end
          end
        end
        ST_ARMED: begin
          // A sample written alongside trig is stored but not counted.
          if (trig) begin
            state    <= ST_POST;
            post_cnt <= '0;
          end
        end
        ST_POST: begin
          if (wr_en) begin
            post_cnt <= post_cnt + 1'b1;
            if (post_cnt == POST_LAST) begin
              state  <= ST_FROZEN;
              frozen <= 1'b1;
            end
          end
        end
        ST_FROZEN: begin
          if (rearm) begin
            state    <= ST_FILL;
            fill_cnt <= '0;
            full     <= 1'b0;
            frozen   <= 1'b0;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule
